// File: rtl/store_drain_buffer.sv
// Retired-store drain buffer: holds committed stores in FIFO order and writes
// them to data memory one at a time, flagging loads that hit a pending store.
module store_drain_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [63:0] st_addr,
  input  logic [63:0] st_data,
  input  logic [3:0]  st_size,
  output logic        retire_stall,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_data,
  output logic [3:0]  mem_size,
  input  logic        mem_ack,
  input  logic [63:0] ld_addr,
  output logic        ld_conflict,
  output logic        empty,
  output logic        overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  logic [63:0]   r_addr [DEPTH];
  logic [63:0]   r_data [DEPTH];
  logic [3:0]    r_size [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic          r_overflow;

  logic          w_legal;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic          w_ld_conflict;

  assign w_legal     = st_valid && ((st_size == 4'd1) || (st_size == 4'd2) ||
                                    (st_size == 4'd4) || (st_size == 4'd8));
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = w_legal && !w_full;
  assign w_pop       = (r_state == S_WRITE) && mem_ack;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Control state: pointers, occupancy, drain FSM and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_state    <= S_IDLE;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_legal && w_full) r_overflow <= 1'b1;
      case (r_state)
        S_IDLE:  if (r_count != '0) r_state <= S_WRITE;
        S_WRITE: if (w_pop && (w_count_nxt == '0)) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Payload storage is deliberately not reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
      r_size[r_tail] <= st_size;
    end
  end

  // An entry is live when its distance from head is below the count.
  always_comb begin
    w_ld_conflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(PW'(PW'(i) - r_head)) < r_count) &&
          (r_addr[PW'(i)][63:3] == ld_addr[63:3])) begin
        w_ld_conflict = 1'b1;
      end
    end
  end

  assign mem_req      = (r_state == S_WRITE);
  assign mem_addr     = mem_req ? r_addr[r_head] : '0;
  assign mem_data     = mem_req ? r_data[r_head] : '0;
  assign mem_size     = mem_req ? r_size[r_head] : '0;
  assign retire_stall = w_full;
  assign ld_conflict  = w_ld_conflict;
  assign empty        = (r_count == '0) && (r_state == S_IDLE);
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: directed scenarios plus random traffic checked
// every cycle against a queue-based model of the buffer.
module tb_store_drain_buffer;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  size;
  } entry_t;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [3:0]  st_size;
  logic        retire_stall;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [63:0] mem_data;
  logic [3:0]  mem_size;
  logic        mem_ack;
  logic [63:0] ld_addr;
  logic        ld_conflict;
  logic        empty;
  logic        overflow;

  store_drain_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .retire_stall(retire_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_size(mem_size),
    .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .empty(empty), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  entry_t q[$];
  bit     m_req;
  bit     m_ovf;
  int     n_written;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] s);
    return (s == 4'd1) || (s == 4'd2) || (s == 4'd4) || (s == 4'd8);
  endfunction

  function automatic bit m_conflict(input logic [63:0] ld);
    foreach (q[i]) if (q[i].addr[63:3] == ld[63:3]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    q.delete();
    m_req = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Compare every output against the model for the current state and inputs.
  task automatic check_all();
    logic [63:0] ea, ed;
    logic [3:0]  es;
    ea = '0; ed = '0; es = '0;
    if (m_req && q.size() > 0) begin
      ea = q[0].addr; ed = q[0].data; es = q[0].size;
    end
    chk("mem_req",      64'(mem_req),      64'(m_req));
    chk("mem_addr",     mem_addr,          ea);
    chk("mem_data",     mem_data,          ed);
    chk("mem_size",     64'(mem_size),     64'(es));
    chk("retire_stall", 64'(retire_stall), 64'(q.size() == DEPTH));
    chk("empty",        64'(empty),        64'(q.size() == 0 && !m_req));
    chk("overflow",     64'(overflow),     64'(m_ovf));
    chk("ld_conflict",  64'(ld_conflict),  64'(m_conflict(ld_addr)));
    if (reset && mem_req && mem_ack) n_written++;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit pop, legal, full, had;
    entry_t e;
    pop   = m_req && mem_ack;
    legal = st_valid && is_legal(st_size);
    full  = (q.size() == DEPTH);
    had   = (q.size() > 0);
    if (legal && full) m_ovf = 1'b1;
    if (pop) void'(q.pop_front());
    if (legal && !full) begin
      e.addr = st_addr; e.data = st_data; e.size = st_size;
      q.push_back(e);
    end
    if (!m_req) m_req = had;
    else if (pop) m_req = (q.size() > 0);
  endtask

  task automatic step(input logic v, input logic [63:0] a, input logic [63:0] d,
                      input logic [3:0] s, input logic ack, input logic [63:0] ld);
    st_valid = v; st_addr = a; st_data = d; st_size = s; mem_ack = ack; ld_addr = ld;
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rand_size();
    if ($urandom_range(0, 3) != 0) return 4'(1 << $urandom_range(0, 3));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    int w0, pushed, guard;
    logic [63:0] a;
    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    mem_ack = 1'b0; ld_addr = '0;
    n_written = 0;
    m_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    reset = 1'b1;

    // Single store with ack tied high: exactly one write, then empty.
    w0 = n_written;
    step(1'b1, 64'h1000, 64'hAB, 4'd1, 1'b1, '0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 4'd0, 1'b1, '0);
    chk("single_writes", 64'(n_written - w0), 64'd1);
    chk("single_empty", 64'(empty), 64'd1);

    // Fill to DEPTH, overflow on the fifth, then drain in push order.
    for (int i = 0; i < 4; i++)
      step(1'b1, 64'h100 * 64'(i + 1), 64'hD0 + 64'(i), 4'd8, 1'b0, '0);
    chk("stall_full", 64'(retire_stall), 64'd1);
    step(1'b1, 64'h900, 64'h99, 4'd4, 1'b0, '0);
    chk("overflow_set", 64'(overflow), 64'd1);
    step(1'b0, '0, '0, 4'd0, 1'b1, '0);
    chk("stall_drop", 64'(retire_stall), 64'd0);
    chk("head_after_ack", mem_addr, 64'h200);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 4'd0, 1'b1, '0);

    // Reset mid-request with three entries pending.
    w0 = n_written;
    for (int i = 0; i < 3; i++)
      step(1'b1, 64'h4000 + 64'(i * 8), 64'(i), 4'd2, 1'b0, '0);
    chk("pre_reset_req", 64'(mem_req), 64'd1);
    reset = 1'b0;
    #1;
    m_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 64'h5000, 64'h55, 4'd0, 1'b1, '0);
    chk("reset_no_write", 64'(n_written - w0), 64'd0);

    // Push with pop at count 2: count holds and head moves to second-oldest.
    step(1'b1, 64'h6000, 64'hA, 4'd8, 1'b0, '0);
    step(1'b1, 64'h6008, 64'hB, 4'd8, 1'b0, '0);
    step(1'b1, 64'h6010, 64'hC, 4'd8, 1'b1, '0);
    chk("pp_head", mem_addr, 64'h6008);
    chk("pp_data", mem_data, 64'hB);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 4'd0, 1'b1, '0);

    // Load conflict on doubleword granularity, held until the ack completes.
    step(1'b1, 64'h2004, 64'h77, 4'd4, 1'b0, 64'h2000);
    step(1'b0, '0, '0, 4'd0, 1'b0, 64'h2000);
    chk("ld_hit", 64'(ld_conflict), 64'd1);
    step(1'b0, '0, '0, 4'd0, 1'b0, 64'h2008);
    chk("ld_miss", 64'(ld_conflict), 64'd0);
    step(1'b0, '0, '0, 4'd0, 1'b1, 64'h2000);
    chk("ld_after_ack", 64'(ld_conflict), 64'd0);

    // Ten stores through the ring with random ack gaps.
    w0 = n_written; pushed = 0; guard = 0;
    while ((pushed < 10 || q.size() > 0 || m_req) && guard < 300) begin
      logic v;
      v = (pushed < 10) && (q.size() < DEPTH);
      a = 64'h8000 + 64'(pushed * 16);
      step(v, a, {$urandom, $urandom}, 4'(1 << $urandom_range(0, 3)),
           1'($urandom_range(0, 2) != 0), a);
      if (v) pushed++;
      guard++;
    end
    chk("wrap_writes", 64'(n_written - w0), 64'd10);
    chk("wrap_drained", 64'(q.size()), 64'd0);
    chk("wrap_no_ovf", 64'(overflow), 64'd0);

    // Random traffic, including illegal sizes and idle acks.
    for (int i = 0; i < 400; i++) begin
      a = 64'h3000 + 64'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, rand_size(),
           1'($urandom_range(0, 1)), 64'h3000 + 64'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 4'd0, 1'b1, '0);
    chk("final_empty", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
